// File: rtl/ece429_pipeline_interlock.sv
// ============================================================================
//  Module      : ece429_pipeline_interlock
//  Description : Decode-side interlock for a 5-stage F/D/X/M/W pipeline.
//                Tracks the instruction in X and stalls for load-use hazards
//                that bypassing cannot cover. Holds the front end while a
//                multi-cycle MUL occupies X. Squashes F/D on a taken
//                branch/jump resolved in X. Counts front-end stall cycles.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ece429_pipeline_interlock #(
   parameter int MUL_LATENCY = 4,   // cycles a MUL occupies X (>= 2)
   parameter int CNT_W       = 16   // stall-cycle counter width
) (
   input  logic             clock_i,
   input  logic             reset_ni,       // asynchronous, active-low
   input  logic             d_valid_i,
   input  logic [4:0]       d_rs_i,
   input  logic [4:0]       d_rt_i,
   input  logic             d_read_rs_i,
   input  logic             d_read_rt_i,
   input  logic [4:0]       d_dest_i,
   input  logic             d_reg_write_i,
   input  logic             d_is_load_i,
   input  logic             d_is_mul_i,
   input  logic             x_br_taken_i,
   output logic             f_enable_o,
   output logic             d_enable_o,
   output logic             d_squash_o,
   output logic             x_bubble_o,
   output logic             x_hold_o,
   output logic             m_bubble_o,
   output logic [CNT_W-1:0] stall_count_o
);

   // The MUL counter holds the number of hold cycles still to come, so it
   // must be able to represent MUL_LATENCY-1.
   localparam int MC_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MUL_BUSY   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q;

   // Shadow of the instruction currently in X
   logic              x_valid_q;
   logic [4:0]        x_dest_q;
   logic              x_reg_write_q;
   logic              x_is_load_q;

   logic              w_haz;
   logic              w_mul_hold;
   logic              w_advance;

   // Load-use hazard: a load in X writing a register the D instruction reads.
   // Register $0 is hard-wired zero and can never create a dependency.
   always_comb begin
      w_haz = x_valid_q & x_is_load_q & x_reg_write_q & (x_dest_q != 5'd0) & d_valid_i &
              ((d_read_rs_i & (d_rs_i == x_dest_q)) | (d_read_rt_i & (d_rt_i == x_dest_q)));
   end

   // Stage-control decode and next-state selection. In MUL_BUSY the counter
   // reaching zero is the release cycle, which otherwise behaves like RUN
   // except that a branch cannot be in X (X still holds the MUL).
   always_comb begin
      f_enable_o = 1'b1;
      d_enable_o = 1'b1;
      d_squash_o = 1'b0;
      x_bubble_o = 1'b0;
      x_hold_o   = 1'b0;
      m_bubble_o = 1'b0;
      state_d    = ST_RUN;
      mul_cnt_d  = '0;
      w_mul_hold = (state_q == ST_MUL_BUSY) && (mul_cnt_q != '0);

      if (w_mul_hold) begin
         f_enable_o = 1'b0;
         d_enable_o = 1'b0;
         x_hold_o   = 1'b1;
         m_bubble_o = 1'b1;
         state_d    = ST_MUL_BUSY;
         mul_cnt_d  = mul_cnt_q - MC_W'(1);
      end else if (x_br_taken_i && (state_q != ST_MUL_BUSY)) begin
         // Taken branch wins over a hazard: the dependent insn is discarded.
         d_squash_o = 1'b1;
         x_bubble_o = 1'b1;
      end else if (w_haz) begin
         f_enable_o = 1'b0;
         d_enable_o = 1'b0;
         x_bubble_o = 1'b1;
         state_d    = ST_LOAD_STALL;
      end else if (d_valid_i && d_is_mul_i) begin
         state_d    = ST_MUL_BUSY;
         mul_cnt_d  = MC_W'(MUL_LATENCY - 1);
      end
   end

   assign w_advance     = d_enable_o & ~x_bubble_o & ~d_squash_o;
   assign stall_count_o = stall_cnt_q;

   // Control state and MUL occupancy counter
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_RUN;
         mul_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
      end
   end

   // X shadow: load from D when it advances, hold under a MUL, else bubble
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         x_valid_q     <= 1'b0;
         x_dest_q      <= 5'd0;
         x_reg_write_q <= 1'b0;
         x_is_load_q   <= 1'b0;
      end else if (x_hold_o) begin
         x_valid_q     <= x_valid_q;
         x_dest_q      <= x_dest_q;
         x_reg_write_q <= x_reg_write_q;
         x_is_load_q   <= x_is_load_q;
      end else if (w_advance) begin
         x_valid_q     <= d_valid_i;
         x_dest_q      <= d_dest_i;
         x_reg_write_q <= d_reg_write_i;
         x_is_load_q   <= d_is_load_i;
      end else begin
         x_valid_q     <= 1'b0;
         x_dest_q      <= 5'd0;
         x_reg_write_q <= 1'b0;
         x_is_load_q   <= 1'b0;
      end
   end

   // Saturating count of cycles in which the PC did not load
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         stall_cnt_q <= '0;
      end else if (!f_enable_o && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ece429_pipeline_interlock.sv
// ============================================================================
//  Module      : tb_ece429_pipeline_interlock
//  Description : Directed-vector bench for ece429_pipeline_interlock with a
//                queue scoreboard: the driver pushes the expected stage
//                controls and stall count, a negedge monitor pops and checks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ece429_pipeline_interlock;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       rrs;
      logic       rrt;
      logic [4:0] dest;
      logic       rw;
      logic       ld;
      logic       mul;
      logic       br;
   } vec_t;

   typedef struct packed {
      logic [5:0]  o;     // {f_en, d_en, d_squash, x_bubble, x_hold, m_bubble}
      logic [15:0] cnt;
      logic [7:0]  id;
   } exp_t;

   localparam logic [5:0] RUNO = 6'b110000;
   localparam logic [5:0] LUST = 6'b000100;
   localparam logic [5:0] SQ   = 6'b111100;
   localparam logic [5:0] MULH = 6'b000011;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sat_rst_n = 1'b0;
   vec_t        in_v = '0;
   logic        f_en, d_en, d_sq, x_bub, x_hld, m_bub;
   logic [15:0] stall_cnt;
   logic        s_f_en, s_d_en, s_d_sq, s_x_bub, s_x_hld, s_m_bub;
   logic [15:0] s_stall_cnt;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          step_id = 0;

   always #5 clk = ~clk;

   ece429_pipeline_interlock #(.MUL_LATENCY(4), .CNT_W(16)) u_dut (
      .clock_i(clk), .reset_ni(rst_n),
      .d_valid_i(in_v.v), .d_rs_i(in_v.rs), .d_rt_i(in_v.rt),
      .d_read_rs_i(in_v.rrs), .d_read_rt_i(in_v.rrt), .d_dest_i(in_v.dest),
      .d_reg_write_i(in_v.rw), .d_is_load_i(in_v.ld), .d_is_mul_i(in_v.mul),
      .x_br_taken_i(in_v.br),
      .f_enable_o(f_en), .d_enable_o(d_en), .d_squash_o(d_sq),
      .x_bubble_o(x_bub), .x_hold_o(x_hld), .m_bubble_o(m_bub),
      .stall_count_o(stall_cnt)
   );

   // Long-latency instance: back-to-back MULs drive the counter into saturation
   ece429_pipeline_interlock #(.MUL_LATENCY(256), .CNT_W(16)) u_sat (
      .clock_i(clk), .reset_ni(sat_rst_n),
      .d_valid_i(1'b1), .d_rs_i(5'd1), .d_rt_i(5'd2),
      .d_read_rs_i(1'b1), .d_read_rt_i(1'b1), .d_dest_i(5'd3),
      .d_reg_write_i(1'b1), .d_is_load_i(1'b0), .d_is_mul_i(1'b1),
      .x_br_taken_i(1'b0),
      .f_enable_o(s_f_en), .d_enable_o(s_d_en), .d_squash_o(s_d_sq),
      .x_bubble_o(s_x_bub), .x_hold_o(s_x_hld), .m_bubble_o(s_m_bub),
      .stall_count_o(s_stall_cnt)
   );

   function automatic vec_t nop();
      return '0;
   endfunction

   function automatic vec_t lw(input logic [4:0] rt, input logic [4:0] base);
      vec_t v = '0;
      v.v = 1'b1; v.rs = base; v.rrs = 1'b1; v.dest = rt; v.rw = 1'b1; v.ld = 1'b1;
      return v;
   endfunction

   function automatic vec_t rtyp(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      vec_t v = '0;
      v.v = 1'b1; v.rs = rs; v.rt = rt; v.rrs = 1'b1; v.rrt = 1'b1; v.dest = rd; v.rw = 1'b1;
      return v;
   endfunction

   function automatic vec_t mul(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
      vec_t v = rtyp(rd, rs, rt);
      v.mul = 1'b1;
      return v;
   endfunction

   // Shift: rs field carries junk but is not read
   function automatic vec_t sll(input logic [4:0] rd, input logic [4:0] rt, input logic [4:0] rs_junk);
      vec_t v = '0;
      v.v = 1'b1; v.rs = rs_junk; v.rt = rt; v.rrt = 1'b1; v.dest = rd; v.rw = 1'b1;
      return v;
   endfunction

   function automatic vec_t beq(input logic [4:0] rs, input logic [4:0] rt);
      vec_t v = '0;
      v.v = 1'b1; v.rs = rs; v.rt = rt; v.rrs = 1'b1; v.rrt = 1'b1;
      return v;
   endfunction

   function automatic vec_t taken(input vec_t v_in);
      vec_t v = v_in;
      v.br = 1'b1;
      return v;
   endfunction

   // One cycle of stimulus: drive just after the edge, queue the expectation
   task automatic cyc(input logic rn, input vec_t v, input logic [5:0] eo, input int ec);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rn;
      in_v  = v;
      step_id++;
      e.o   = eo;
      e.cnt = 16'(ec);
      e.id  = 8'(step_id);
      sb.push_back(e);
   endtask

   // Monitor: compare on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [5:0] act;
         e   = sb.pop_front();
         act = {f_en, d_en, d_sq, x_bub, x_hld, m_bub};
         checks++;
         if (act !== e.o || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL step%0d ctrl got %b want %b stall_count got %0d want %0d",
                     e.id, act, e.o, stall_cnt, e.cnt);
         end
      end
   end

   task automatic run_main();
      // Reset state
      cyc(0, nop(), RUNO, 0);
      cyc(0, nop(), RUNO, 0);
      // Load-use on rs: one stall cycle
      cyc(1, lw(5, 1),       RUNO, 0);
      cyc(1, rtyp(6, 5, 2),  LUST, 0);
      cyc(1, rtyp(6, 5, 2),  RUNO, 1);
      cyc(1, nop(),          RUNO, 1);
      // $0 destination exempt; unread rs field exempt
      cyc(1, lw(0, 1),       RUNO, 1);
      cyc(1, rtyp(6, 0, 2),  RUNO, 1);
      cyc(1, lw(5, 1),       RUNO, 1);
      cyc(1, sll(6, 7, 5),   RUNO, 1);
      // Load-use through rt
      cyc(1, lw(5, 1),       RUNO, 1);
      cyc(1, rtyp(6, 1, 5),  LUST, 1);
      cyc(1, rtyp(6, 1, 5),  RUNO, 2);
      cyc(1, nop(),          RUNO, 2);
      // MUL, then a second MUL directly behind
      cyc(1, mul(3, 1, 2),   RUNO, 2);
      cyc(1, mul(4, 3, 1),   MULH, 2);
      cyc(1, mul(4, 3, 1),   MULH, 3);
      cyc(1, mul(4, 3, 1),   MULH, 4);
      cyc(1, mul(4, 3, 1),   RUNO, 5);
      cyc(1, nop(),          MULH, 5);
      cyc(1, nop(),          MULH, 6);
      cyc(1, nop(),          MULH, 7);
      cyc(1, nop(),          RUNO, 8);
      cyc(1, nop(),          RUNO, 8);
      // Taken branch together with a load-use hazard: squash, no stall
      cyc(1, lw(5, 1),              RUNO, 8);
      cyc(1, taken(rtyp(6, 5, 2)),  SQ,   8);
      cyc(1, nop(),                 RUNO, 8);
      // Plain taken branch
      cyc(1, beq(1, 2),             RUNO, 8);
      cyc(1, taken(rtyp(7, 1, 2)),  SQ,   8);
      cyc(1, nop(),                 RUNO, 8);
      // Branch-taken asserted during MUL_BUSY is ignored
      cyc(1, mul(3, 1, 2),   RUNO, 8);
      cyc(1, taken(nop()),   MULH, 8);
      cyc(1, nop(),          MULH, 9);
      cyc(1, nop(),          MULH, 10);
      cyc(1, nop(),          RUNO, 11);
      // Load followed by a dependent MUL: load-use stall then MUL hold
      cyc(1, lw(5, 1),       RUNO, 11);
      cyc(1, mul(3, 5, 1),   LUST, 11);
      cyc(1, mul(3, 5, 1),   RUNO, 12);
      cyc(1, nop(),          MULH, 12);
      cyc(1, nop(),          MULH, 13);
      cyc(1, nop(),          MULH, 14);
      cyc(1, nop(),          RUNO, 15);
      // Reset asserted mid-cycle while mul_cnt is 2
      cyc(1, mul(3, 1, 2),   RUNO, 15);
      cyc(1, nop(),          MULH, 15);
      cyc(0, nop(),          RUNO, 0);
      cyc(0, nop(),          RUNO, 0);
      cyc(1, rtyp(6, 5, 2),  RUNO, 0);
      cyc(1, rtyp(7, 6, 1),  RUNO, 0);
      cyc(1, nop(),          RUNO, 0);
   endtask

   task automatic run_sat();
      repeat (2) @(posedge clk);
      #1 sat_rst_n = 1'b1;
      // Each 256-cycle MUL period yields 255 stall cycles
      repeat (512) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_stall_cnt !== 16'd510) begin
         errors++;
         $display("FAIL sat_mid stall_count got %0d want 510", s_stall_cnt);
      end
      // Well over 2^16+5 stall cycles in total
      repeat (65600) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_stall_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_end stall_count got %h want ffff", s_stall_cnt);
      end
   endtask

   initial begin
      fork
         run_main();
         run_sat();
      join
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain pending got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
